// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the write-back queue.
//   REG_ADDR_W : register address width (r0 is the hard-wired zero register)
//   DATA_W     : default register data width
//   wbq_entry_t: one queue slot {valid, rd, data}
package wb_write_queue_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_bypass_match.sv
// One bypass lookup against every queue slot.
//   addr_i  : lookup register address (0 never hits)
//   head_i  : slot index of the oldest entry
//   valid_i : per-slot valid bits
//   regs_i  : per-slot destination registers
//   data_i  : per-slot data
//   hit_o   : some valid slot matches addr_i
//   byp_o   : data of the youngest matching slot, 0 on a miss
module wbq_bypass_match
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [REG_ADDR_W-1:0]            addr_i,
    input  logic [AW-1:0]                    head_i,
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] regs_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]     data_i,
    output logic                             hit_o,
    output logic [DATA_W-1:0]                byp_o
);

    logic [AW-1:0] idx;

    // Walk slots oldest to youngest from the head; a later match overrides
    // an earlier one, so the youngest writer wins.
    always_comb begin
        hit_o = 1'b0;
        byp_o = '0;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i + AW'(k);
            if ((addr_i != '0) && valid_i[idx] && (regs_i[idx] == addr_i)) begin
                hit_o = 1'b1;
                byp_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue between the Mem/Alu result offers and a
// single register-file write port, with three pending-write bypass lookups.
//   CLK, RESET                 : clock, asynchronous active-high reset
//   MemValid/MemReg/MemData    : older result offer, MemReady handshake
//   AluValid/AluReg/AluData    : younger result offer, AluReady handshake
//   Write1/WriteReg1/WriteData1: head entry, committed every cycle it is shown
//   RegA1/B1/C1                : bypass lookup addresses
//   HitA1/B1/C1, BypA1/B1/C1   : bypass results over queued entries
//   Count                      : number of valid entries
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MemValid,
    input  logic [REG_ADDR_W-1:0] MemReg,
    input  logic [DATA_W-1:0]     MemData,
    input  logic                  AluValid,
    input  logic [REG_ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0]     AluData,
    output logic                  MemReady,
    output logic                  AluReady,
    output logic                  Write1,
    output logic [REG_ADDR_W-1:0] WriteReg1,
    output logic [DATA_W-1:0]     WriteData1,
    input  logic [REG_ADDR_W-1:0] RegA1,
    input  logic [REG_ADDR_W-1:0] RegB1,
    input  logic [REG_ADDR_W-1:0] RegC1,
    output logic                  HitA1,
    output logic                  HitB1,
    output logic                  HitC1,
    output logic [DATA_W-1:0]     BypA1,
    output logic [DATA_W-1:0]     BypB1,
    output logic [DATA_W-1:0]     BypC1,
    output logic [CW-1:0]         Count
);

    logic [DEPTH-1:0]                 vld_q,  vld_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q,   rd_d;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q, data_d;
    logic [AW-1:0]                    rptr_q, rptr_d;
    logic [AW-1:0]                    wptr_q, wptr_d;
    logic [CW-1:0]                    count_q, count_d;

    logic          deq;
    logic          mem_enq;
    logic          alu_enq;
    logic [AW-1:0] alu_slot;

    // Readiness looks only at the registered count, so an entry leaving
    // this cycle never frees room for an offer in the same cycle.
    always_comb begin
        MemReady = (count_q < CW'(DEPTH));
        AluReady = (count_q <= CW'(DEPTH - 2));
    end

    // The register file always accepts, so the head commits every cycle
    // it is presented. Offers to r0 are consumed without taking a slot.
    always_comb begin
        deq      = (count_q != '0);
        mem_enq  = MemValid && MemReady && (MemReg != '0);
        alu_enq  = AluValid && AluReady && (AluReg != '0);
        alu_slot = wptr_q + AW'(mem_enq);
    end

    always_comb begin
        Write1     = deq;
        WriteReg1  = '0;
        WriteData1 = '0;
        if (deq) begin
            WriteReg1  = rd_q[rptr_q];
            WriteData1 = data_q[rptr_q];
        end
        Count = count_q;
    end

    always_comb begin
        vld_d  = vld_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (deq) begin
            vld_d[rptr_q] = 1'b0;
        end
        // Enqueue slots are always free, so they never collide with the
        // slot being dequeued. Mem lands ahead of Alu.
        if (mem_enq) begin
            vld_d[wptr_q]  = 1'b1;
            rd_d[wptr_q]   = MemReg;
            data_d[wptr_q] = MemData;
        end
        if (alu_enq) begin
            vld_d[alu_slot]  = 1'b1;
            rd_d[alu_slot]   = AluReg;
            data_d[alu_slot] = AluData;
        end
        rptr_d  = rptr_q + AW'(deq);
        wptr_d  = wptr_q + AW'(mem_enq) + AW'(alu_enq);
        count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_byp_a (
        .addr_i  (RegA1),
        .head_i  (rptr_q),
        .valid_i (vld_q),
        .regs_i  (rd_q),
        .data_i  (data_q),
        .hit_o   (HitA1),
        .byp_o   (BypA1)
    );

    wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_byp_b (
        .addr_i  (RegB1),
        .head_i  (rptr_q),
        .valid_i (vld_q),
        .regs_i  (rd_q),
        .data_i  (data_q),
        .hit_o   (HitB1),
        .byp_o   (BypB1)
    );

    wbq_bypass_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_byp_c (
        .addr_i  (RegC1),
        .head_i  (rptr_q),
        .valid_i (vld_q),
        .regs_i  (rd_q),
        .data_i  (data_q),
        .hit_o   (HitC1),
        .byp_o   (BypC1)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios followed by random offers,
// all checked against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic        MemValid, AluValid;
    logic [4:0]  MemReg, AluReg;
    logic [31:0] MemData, AluData;
    logic        MemReady, AluReady;
    logic        Write1;
    logic [4:0]  WriteReg1;
    logic [31:0] WriteData1;
    logic [4:0]  RegA1, RegB1, RegC1;
    logic        HitA1, HitB1, HitC1;
    logic [31:0] BypA1, BypB1, BypC1;
    logic [2:0]  Count;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MemValid   (MemValid),
        .MemReg     (MemReg),
        .MemData    (MemData),
        .AluValid   (AluValid),
        .AluReg     (AluReg),
        .AluData    (AluData),
        .MemReady   (MemReady),
        .AluReady   (AluReady),
        .Write1     (Write1),
        .WriteReg1  (WriteReg1),
        .WriteData1 (WriteData1),
        .RegA1      (RegA1),
        .RegB1      (RegB1),
        .RegC1      (RegC1),
        .HitA1      (HitA1),
        .HitB1      (HitB1),
        .HitC1      (HitC1),
        .BypA1      (BypA1),
        .BypB1      (BypB1),
        .BypC1      (BypC1),
        .Count      (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   total = 0;
    int   bad = 0;
    int   n_pushed = 0;
    int   n_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference bypass: youngest matching queued entry, r0 never hits.
    function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].r == a) begin
                    h = 1'b1;
                    d = mq[i].d;
                end
            end
        end
    endfunction

    task automatic offer(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        MemValid = mv; MemReg = mr; MemData = md;
        AluValid = av; AluReg = ar; AluData = ad;
    endtask

    task automatic look(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        RegA1 = a; RegB1 = b; RegC1 = c;
    endtask

    // Called just after a falling edge with inputs already driven: check
    // every output against the model, take the rising edge, update model.
    task automatic step();
        logic        h;
        logic [31:0] d;
        logic        mrdy, ardy;
        #1;
        mrdy = (mq.size() < DEPTH);
        ardy = (mq.size() + 2 <= DEPTH);
        chk("count", Count, mq.size());
        chk("mem_ready", MemReady, mrdy);
        chk("alu_ready", AluReady, ardy);
        if (mq.size() > 0) begin
            chk("write1", Write1, 1);
            chk("write_reg", WriteReg1, mq[0].r);
            chk("write_data", WriteData1, mq[0].d);
        end else begin
            chk("write1_idle", Write1, 0);
            chk("write_reg_idle", WriteReg1, 0);
            chk("write_data_idle", WriteData1, 0);
        end
        lookup(RegA1, h, d);
        chk("hitA", HitA1, h);
        chk("bypA", BypA1, d);
        lookup(RegB1, h, d);
        chk("hitB", HitB1, h);
        chk("bypB", BypB1, d);
        lookup(RegC1, h, d);
        chk("hitC", HitC1, h);
        chk("bypC", BypC1, d);
        if (Write1 === 1'b1) n_seen++;
        @(posedge CLK);
        if (mq.size() > 0) void'(mq.pop_front());
        if (MemValid && mrdy && MemReg != 5'd0) begin
            mq.push_back('{MemReg, MemData});
            n_pushed++;
        end
        if (AluValid && ardy && AluReg != 5'd0) begin
            mq.push_back('{AluReg, AluData});
            n_pushed++;
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        offer(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RESET = 1'b1;
        offer(0, 0, 0, 0, 0, 0);
        look(0, 0, 0);
        #1;
        chk("rst_count", Count, 0);
        chk("rst_write1", Write1, 0);
        chk("rst_mem_ready", MemReady, 1);
        chk("rst_alu_ready", AluReady, 1);
        chk("rst_hitA", HitA1, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Scenario 1: single Mem result, one-cycle latency.
        look(5, 0, 0);
        offer(1, 5, 32'h11, 0, 0, 0);
        step();
        offer(0, 0, 0, 0, 0, 0);
        #1;
        chk("s1_write1", Write1, 1);
        chk("s1_reg", WriteReg1, 5);
        chk("s1_data", WriteData1, 32'h11);
        step();
        chk("s1_count_after", Count, 0);
        idle(1);

        // Scenario 2: same register from both offers, Alu is youngest.
        look(3, 0, 3);
        offer(1, 3, 32'hAA, 1, 3, 32'hBB);
        step();
        offer(0, 0, 0, 0, 0, 0);
        #1;
        chk("s2_hitA", HitA1, 1);
        chk("s2_bypA", BypA1, 32'hBB);
        chk("s2_first_write", WriteData1, 32'hAA);
        step();
        chk("s2_second_write", WriteData1, 32'hBB);
        idle(2);

        // Scenario 3: fill to DEPTH-1; Alu must be refused there.
        look(7, 8, 9);
        offer(1, 7, 32'h70, 1, 8, 32'h80);
        step();
        offer(1, 9, 32'h90, 1, 10, 32'hA0);
        step();
        chk("s3_count3", Count, 3);
        chk("s3_mem_ready", MemReady, 1);
        chk("s3_alu_ready", AluReady, 0);
        offer(1, 11, 32'hB0, 1, 12, 32'hC0);
        step();
        idle(5);

        // Scenario 4: offers to r0 are consumed but never written.
        look(0, 0, 0);
        offer(0, 0, 0, 1, 0, 32'hFF);
        step();
        chk("s4_count", Count, 0);
        chk("s4_no_write", Write1, 0);
        chk("s4_hitB", HitB1, 0);
        offer(1, 0, 32'hFE, 1, 0, 32'hFD);
        step();
        idle(1);

        // Scenario 5: dual offers every cycle, pointers wrap many times.
        for (int i = 0; i < 24; i++) begin
            look(5'(1 + i % 6), 5'(2 + i % 6), 5'(3 + i % 6));
            offer(1, 5'(1 + i % 6), 32'h1000 + i, 1, 5'(2 + (i * 3) % 6), 32'h2000 + i);
            step();
        end
        idle(6);
        chk("s5_writes_vs_accepts", n_seen, n_pushed);

        // Scenario 6: reset with three pending entries.
        offer(1, 1, 32'h61, 1, 2, 32'h62);
        step();
        offer(1, 3, 32'h63, 1, 4, 32'h64);
        step();
        chk("s6_pre_count", Count, 3);
        offer(0, 0, 0, 0, 0, 0);
        look(4, 3, 2);
        RESET = 1'b1;
        #1;
        chk("s6_rst_write1", Write1, 0);
        chk("s6_rst_count", Count, 0);
        chk("s6_rst_hitA", HitA1, 0);
        chk("s6_rst_bypA", BypA1, 0);
        chk("s6_rst_mem_ready", MemReady, 1);
        chk("s6_rst_alu_ready", AluReady, 1);
        mq.delete();
        @(posedge CLK);
        #1;
        chk("s6_rst_held_write1", Write1, 0);
        @(negedge CLK);
        RESET = 1'b0;
        idle(4);

        // Random traffic.
        n_seen = 0;
        n_pushed = 0;
        for (int i = 0; i < 300; i++) begin
            look(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            offer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            step();
        end
        idle(6);
        chk("rand_writes_vs_accepts", n_seen, n_pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
